// File: rtl/sap_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sap_program_loader: encodes one-hot mnemonic requests into 8-bit SAP
// instruction words and writes them sequentially into program RAM.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sap_program_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr_sel,
  input  logic [3:0]        operand,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic [ADDR_W:0]   words,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_FULL  = 3'd4
  } state_t;

  localparam logic [3:0]      OP_HLT     = 4'hF;
  localparam logic [ADDR_W:0] WORDS_FULL = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                err_q, err_d;

  logic                sel_legal;
  logic [3:0]          sel_idx;
  logic [ADDR_W:0]     words_inc;

  // Legal means exactly one bit set; the index is only meaningful when legal.
  always_comb begin
    sel_legal = (instr_sel != 16'h0000) &&
                ((instr_sel & (instr_sel - 16'd1)) == 16'h0000);
    sel_idx   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (instr_sel[i]) sel_idx = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    words_d    = words_q;
    done_d     = done_q;
    full_d     = full_q;
    err_d      = 1'b0;
    words_inc  = words_q + 1'b1;

    if (start) begin
      state_d    = S_LOAD;
      mem_addr_d = '0;
      words_d    = '0;
      done_d     = 1'b0;
      full_d     = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            if (sel_legal) begin
              mem_data_d = {sel_idx, (sel_idx == OP_HLT) ? 4'h0 : operand};
              state_d    = S_WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_WRITE: begin
          words_d = words_inc;
          if (mem_data_q[7:4] == OP_HLT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (words_inc == WORDS_FULL) begin
            state_d    = S_FULL;
            full_d     = 1'b1;
            mem_addr_d = '0;
          end else begin
            state_d    = S_LOAD;
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      words_q    <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      words_q    <= words_d;
      done_q     <= done_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  // A start landing in the write cycle aborts that write.
  assign mem_we   = (state_q == S_WRITE) && !start;
  assign in_ready = (state_q == S_LOAD);
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign words    = words_q;
  assign done     = done_q;
  assign full     = full_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sap_program_loader: randomized and directed checks against a
// transaction-level model of the program loader.
// ----------------------------------------------------------------------------
module tb_sap_program_loader;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr_sel = 16'h0000;
  logic [3:0]  operand = 4'h0;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [4:0]  words;
  logic        done;
  logic        full;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Model state
  int          m_addr = 0;
  int          m_words = 0;
  bit          m_done = 0;
  bit          m_full = 0;
  int          m_err = 0;
  int          err_seen = 0;
  logic [11:0] exp_q[$];

  sap_program_loader #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .instr_sel(instr_sel), .operand(operand),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .words(words), .done(done), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Write scoreboard and err pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (err) err_seen++;
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_data);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h exp addr=%0h data=%0h",
                   mem_addr, mem_data, e[11:8], e[7:0]);
        end
      end
    end
  end

  function automatic void model_reset();
    m_addr = 0; m_words = 0; m_done = 0; m_full = 0;
  endfunction

  function automatic void model_accept(input logic [15:0] sel, input logic [3:0] op);
    int idx;
    logic [7:0] d;
    if ($countones(sel) != 1) begin
      m_err++;
      return;
    end
    idx = 0;
    for (int i = 0; i < 16; i++) if (sel[i]) idx = i;
    d = {idx[3:0], (idx == 15) ? 4'h0 : op};
    exp_q.push_back({m_addr[3:0], d});
    m_words++;
    if (idx == 15) m_done = 1;
    else if (m_words == 16) begin m_full = 1; m_addr = 0; end
    else m_addr++;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [15:0] sel, input logic [3:0] op, input bit use_model);
    bit r, ok;
    ok = 0;
    in_valid = 1'b1; instr_sel = sel; operand = op;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got accepted=0 exp accepted=1 sel=%0h", sel);
    end else if (use_model) begin
      model_accept(sel, op);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step(3);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_data, words, done, full, err} !== 23'h0) begin
      errors++;
      $display("FAIL reset got rdy=%b we=%b a=%0h d=%0h w=%0d dn=%b fl=%b e=%b exp all 0",
               in_ready, mem_we, mem_addr, mem_data, words, done, full, err);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    step(2);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b exp 0", in_ready);
    end
    model_reset(); m_err = 0; err_seen = 0;
  endtask

  task automatic test_basic();
    do_start();
    send(16'h0010, 4'hA, 1);
    send(16'h0020, 4'h3, 1);
    send(16'h8000, 4'h9, 1);
    step(1);
    checks++;
    if ({done, full, in_ready, words} !== {1'b1, 1'b0, 1'b0, 5'd3} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic got dn=%b fl=%b rdy=%b w=%0d pend=%0d exp dn=1 fl=0 rdy=0 w=3 pend=0",
               done, full, in_ready, words, exp_q.size());
    end
  endtask

  task automatic test_fill();
    do_start();
    for (int i = 0; i < 16; i++) send(16'h0001, 4'(i), 1);
    step(1);
    checks++;
    if ({full, done, words, mem_addr} !== {1'b1, 1'b0, 5'd16, 4'h0} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill got fl=%b dn=%b w=%0d a=%0h exp fl=1 dn=0 w=16 a=0",
               full, done, words, mem_addr);
    end
  endtask

  task automatic test_illegal();
    int e0;
    do_start();
    e0 = err_seen;
    m_err = 0;
    send(16'h0000, 4'h1, 1);
    send(16'h0011, 4'h2, 1);
    step(2);
    checks++;
    if (err_seen - e0 != m_err || m_err != 2 || mem_addr !== 4'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal got errs=%0d a=%0h rdy=%b exp errs=2 a=0 rdy=1",
               err_seen - e0, mem_addr, in_ready);
    end
    send(16'h0002, 4'h7, 1);
    step(1);
    checks++;
    if (words !== 5'd1 || mem_addr !== 4'h1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_then_sta got w=%0d a=%0h exp w=1 a=1", words, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), 8'hB5});
    in_valid = 1'b1; instr_sel = 16'h0800; operand = 4'h5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (c % 2 == 0) || mem_we !== (c % 2 == 1)) begin
        errors++;
        $display("FAIL b2b cycle %0d got rdy=%b we=%b exp rdy=%b we=%b",
                 c, in_ready, mem_we, (c % 2 == 0), (c % 2 == 1));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    m_addr = 3; m_words = 3;
    checks++;
    if (words !== 5'd3 || mem_addr !== 4'h3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end got w=%0d a=%0h exp w=3 a=3", words, mem_addr);
    end
  endtask

  task automatic test_abort();
    do_start();
    send(16'h4000, 4'h2, 0);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_we got %b exp 0", mem_we);
    end
    @(posedge clk); #1;
    start = 1'b0;
    model_reset();
    checks++;
    if ({in_ready, mem_addr, words, done, full} !== {1'b1, 4'h0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_state got rdy=%b a=%0h w=%0d exp rdy=1 a=0 w=0",
               in_ready, mem_addr, words);
    end
    send(16'h0100, 4'h1, 1);
    step(1);
    checks++;
    if (words !== 5'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_next got w=%0d exp 1", words);
    end
  endtask

  task automatic test_hlt16();
    do_start();
    for (int i = 0; i < 15; i++) send(16'h0008, 4'($urandom_range(0, 15)), 1);
    send(16'h8000, 4'hC, 1);
    step(1);
    checks++;
    if ({done, full, words, mem_addr} !== {1'b1, 1'b0, 5'd16, 4'hF} || exp_q.size() != 0) begin
      errors++;
      $display("FAIL hlt16 got dn=%b fl=%b w=%0d a=%0h exp dn=1 fl=0 w=16 a=f",
               done, full, words, mem_addr);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int e0, n;
      do_start();
      e0 = err_seen; m_err = 0;
      n = $urandom_range(4, 24);
      for (int k = 0; k < n && !m_done && !m_full; k++) begin
        logic [15:0] sel;
        if ($urandom_range(0, 3) == 0) sel = 16'($urandom) | 16'h0003;
        else if ($urandom_range(0, 9) == 0) sel = 16'h8000;
        else sel = 16'h0001 << $urandom_range(0, 14);
        if ($urandom_range(0, 7) == 0) sel = 16'h0000;
        send(sel, 4'($urandom), 1);
        step($urandom_range(0, 2));
      end
      step(2);
      checks++;
      if (words !== 5'(m_words) || done !== m_done || full !== m_full ||
          mem_addr !== 4'(m_addr) || err_seen - e0 != m_err || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random round %0d got w=%0d dn=%b fl=%b a=%0h errs=%0d exp w=%0d dn=%b fl=%b a=%0h errs=%0d",
                 r, words, done, full, mem_addr, err_seen - e0,
                 m_words, m_done, m_full, m_addr, m_err);
      end
    end
  endtask

  task automatic test_clr_mid();
    do_start();
    send(16'h0004, 4'h3, 1);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    model_reset();
    in_valid = 1'b1; instr_sel = 16'h0010; operand = 4'h1;
    step(5);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, words, mem_addr, done, full} !== {1'b0, 5'd0, 4'h0, 1'b0, 1'b0} ||
        exp_q.size() != 0) begin
      errors++;
      $display("FAIL clr_mid got rdy=%b w=%0d a=%0h exp rdy=0 w=0 a=0",
               in_ready, words, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_hlt16();
    test_random();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
